dmem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-ported data memory of the RISC-V core. It shares the DMEM port between the core load/store path (port C) and a debug/program-loader master (port D). Each transaction runs through a small FSM that grants one requester, drives the memory for one cycle, and returns read data one cycle later. Port C has fixed priority; an optional starvation guard bounds how long port D can wait.

---
 rtl/dmem_arbiter.sv | 94 +++++++++
 tb/tb_dmem_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core C, debug D) arbiter and IDLE/ACCESS/RESP sequencer for a single-ported DMEM.
// Optional D starvation guard enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, own_q, own_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic d_win, acc, resp;
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT out of range 1..255");
  end
`ifdef DMEM_ARB_STARVE_EN
  logic [7:0] wait_q, wait_d;
  assign d_win = d_req && (!c_req || wait_q == 8'(STARVE_LIMIT));
  // d_req high without a D win implies C won, and wait_q < STARVE_LIMIT, so +1 saturates naturally
  always_comb wait_d = (state_q != IDLE) ? wait_q : (!d_req || d_win) ? 8'd0 : wait_q + 8'd1;
  always_ff @(posedge clk)
    if (rst) wait_q <= '0;
    else wait_q <= wait_d;
`else
  assign d_win = d_req && !c_req;
`endif
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    own_d   = own_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && (c_req || d_req)) begin
      state_d = ACCESS;
      own_d   = d_win;
      we_d    = d_win ? d_we : c_we;
      addr_d  = d_win ? d_addr : c_addr;
      wdata_d = d_win ? d_wdata : c_wdata;
    end else if (state_q == ACCESS) state_d = we_q ? IDLE : RESP;
    else if (state_q == RESP) state_d = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      own_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  // rst gates the decode so an in-flight access is killed in the reset cycle itself
  assign acc       = !rst && state_q == ACCESS;
  assign resp      = !rst && state_q == RESP;
  assign busy      = !rst && state_q != IDLE;
  assign mem_en    = acc;
  assign mem_we    = acc && we_q;
  assign mem_addr  = rst ? '0 : addr_q;
  assign mem_wdata = rst ? '0 : wdata_q;
  assign c_gnt     = acc && !own_q;
  assign d_gnt     = acc && own_q;
  assign c_rvalid  = resp && !own_q;
  assign d_rvalid  = resp && own_q;
  assign c_rdata   = c_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;
  localparam int LIM = 3;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic c_req = 0, c_we = 0, c_gnt, c_rvalid, d_req = 0, d_we = 0, d_gnt, d_rvalid;
  logic [31:0] c_addr = 0, c_wdata = 0, c_rdata, d_addr = 0, d_wdata = 0, d_rdata;
  logic mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic pl_en = 0;
  logic [5:0] pl_idx = 0;
  logic [31:0] pl_data = 0;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int checks = 0, failures = 0, streak = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_en) mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    pl_en = 1; pl_idx = 6'(idx); pl_data = v; ref_mem[idx] = v;
    @(negedge clk);
    pl_en = 0;
  endtask

  task automatic serve(input bit p, input bit w, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(p ? d_gnt : c_gnt) && n < 8);
    chk("gnt_latency", n, 1);
    chk("gnt_owner", p ? d_gnt : c_gnt, 1);
    chk("gnt_other", p ? c_gnt : d_gnt, 0);
    chk("mem_en", mem_en, 1);
    chk("mem_we", mem_we, w);
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, wd);
    chk("busy_access", busy, 1);
    if (p) begin d_req = 0; d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we; end
    else begin c_req = 0; c_addr = $urandom; c_wdata = $urandom; c_we = ~c_we; end
    if (w) ref_mem[a[7:2]] = wd;
    else begin
      @(negedge clk);
      chk("rvalid_owner", p ? d_rvalid : c_rvalid, 1);
      chk("rvalid_other", p ? c_rvalid : d_rvalid, 0);
      chk("rdata_owner", p ? d_rdata : c_rdata, ref_mem[a[7:2]]);
      chk("rdata_other", p ? c_rdata : d_rdata, 0);
      chk("mem_en_resp", mem_en, 0);
    end
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("idle_gnt", {c_gnt, d_gnt, c_rvalid, d_rvalid}, 0);
  endtask

  task automatic txn(input bit c_on, input bit c_w, input logic [31:0] ca, input logic [31:0] cd,
                     input bit d_on, input bit d_w, input logic [31:0] da, input logic [31:0] dd);
    bit c_first;
    if (c_on) begin c_req = 1; c_we = c_w; c_addr = ca; c_wdata = cd; end
    if (d_on) begin d_req = 1; d_we = d_w; d_addr = da; d_wdata = dd; end
    c_first = c_on && !(GUARD && d_on && streak == LIM);
    if (c_first) begin
      streak = d_on ? (streak < LIM ? streak + 1 : streak) : 0;
      serve(0, c_w, ca, cd);
      if (d_on) begin streak = 0; serve(1, d_w, da, dd); end
    end else if (d_on) begin
      streak = 0;
      serve(1, d_w, da, dd);
      if (c_on) serve(0, c_w, ca, cd);
    end
  endtask

  function automatic logic [31:0] raddr();
    return ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2);
  endfunction

  initial begin
    int ng, nd;
    bit exp_d;
    repeat (2) @(negedge clk);
    chk("rst_outs", {c_gnt, d_gnt, c_rvalid, d_rvalid, mem_en, mem_we, busy}, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_outs", {c_gnt, d_gnt, c_rvalid, d_rvalid, mem_en, mem_we, busy}, 0);
    chk("post_rst_rdata", c_rdata | d_rdata | mem_wdata | mem_addr, 0);
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    preload(4, 32'hDEADBEEF);
    preload(12, 32'h0000_0055);
    txn(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678);
    txn(1, 0, 32'h20, 32'h0, 0, 0, 0, 0);
    txn(1, 1, 32'h24, 32'h0BADF00D, 1, 0, 32'h24, 32'h0);
    // command change after the sample edge must not reach the memory
    c_req = 1; c_we = 0; c_addr = 32'h10;
    @(negedge clk);
    chk("chg_gnt", c_gnt, 1);
    c_addr = 32'h40; c_req = 0;
    #1 chk("chg_mem_addr", mem_addr, 32'h10);
    @(negedge clk);
    chk("chg_rdata", c_rdata, 32'hDEADBEEF);
    @(negedge clk);
    // reset during D's write access
    d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'hAA;
    @(negedge clk);
    chk("rstw_gnt_before", d_gnt, 1);
    rst = 1;
    #1;
    chk("rstw_mem_we", mem_we, 0);
    chk("rstw_mem_en", mem_en, 0);
    chk("rstw_gnt", d_gnt, 0);
    @(negedge clk);
    rst = 0; d_req = 0; streak = 0;
    #1;
    chk("rstw_outs", {c_gnt, d_gnt, c_rvalid, d_rvalid, mem_en, mem_we, busy}, 0);
    chk("rstw_bus", mem_addr | mem_wdata | c_rdata | d_rdata, 0);
    @(negedge clk);
    txn(1, 0, 32'h30, 32'h0, 0, 0, 0, 0);
    // both requesters held continuously with writes
    c_req = 1; c_we = 1; c_addr = 32'hC0; c_wdata = $urandom;
    d_req = 1; d_we = 1; d_addr = 32'hC4; d_wdata = $urandom;
    ng = 0; nd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (c_gnt || d_gnt) begin
        exp_d = GUARD && streak == LIM;
        chk("cont_c_gnt", c_gnt, !exp_d);
        chk("cont_d_gnt", d_gnt, exp_d);
        streak = exp_d ? 0 : (streak < LIM ? streak + 1 : streak);
        if (exp_d) begin ref_mem[49] = d_wdata; nd++; end
        else ref_mem[48] = c_wdata;
        ng++;
      end
    end
    c_req = 0; d_req = 0; streak = 0;
    chk("cont_grants", ng, 25);
    chk("cont_d_grants", nd, GUARD ? 25 / (LIM + 1) : 0);
    repeat (3) @(negedge clk);
    txn(1, 0, 32'hC0, 32'h0, 1, 0, 32'hC4, 32'h0);
    for (int i = 0; i < 40; i++)
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), raddr(), $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), raddr(), $urandom);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
